// File: rtl/au_dec_cnt_pkg.sv
// Shared encodings for the loadable down-counter and its step subtractor.
// Build option AU_DEC_CNT_UFL_STICKY_EN is consumed by au_dec_cnt, not here.
package au_dec_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_WRAP    = 2'd1;
  localparam logic [1:0] MODE_RELOAD  = 2'd2;

  // Prefix networks selectable for the step subtractor.
  localparam int ARCH_KOGGE_STONE = 0;
  localparam int ARCH_SKLANSKY    = 1;
  localparam int ARCH_RIPPLE      = 2;
  localparam int ARCH_MIN         = ARCH_KOGGE_STONE;
  localparam int ARCH_MAX         = ARCH_RIPPLE;

endpackage

// File: rtl/au_dec_step.sv
// Combinational a - zext(b) using a borrow-lookahead prefix network.
// ARCH picks the network topology; the result is identical for every choice.
import au_dec_cnt_pkg::*;

module au_dec_step #(
  parameter int WIDTH = 8,
  parameter int SW    = 4,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             hit
);

  logic [WIDTH-1:0] b_ext;
  logic [WIDTH-1:0] grp_gen;

  assign b_ext = WIDTH'(b);

  // Bit i generates a borrow when a=0,b=1 and passes one through when a==b.
  always_comb begin
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    g = ~a & b_ext;
    p = ~(a ^ b_ext);
    if (ARCH == ARCH_KOGGE_STONE) begin
      for (int d = 1; d < WIDTH; d = d * 2) begin
        for (int i = WIDTH - 1; i >= d; i--) begin
          g[i] = g[i] | (p[i] & g[i-d]);
          p[i] = p[i] & p[i-d];
        end
      end
    end else if (ARCH == ARCH_SKLANSKY) begin
      // Partner is the top bit of the preceding aligned group, untouched at this level.
      for (int d = 1; d < WIDTH; d = d * 2) begin
        for (int i = 0; i < WIDTH; i++) begin
          if ((i & d) != 0) begin
            g[i] = g[i] | (p[i] & g[(i & ~(d - 1)) - 1]);
            p[i] = p[i] & p[(i & ~(d - 1)) - 1];
          end
        end
      end
    end else begin
      for (int i = 1; i < WIDTH; i++) begin
        g[i] = g[i] | (p[i] & g[i-1]);
      end
    end
    grp_gen = g;
  end

  assign diff   = a ^ b_ext ^ (grp_gen << 1);
  assign borrow = grp_gen[WIDTH-1];
  assign hit    = (b != '0) && (borrow || (diff == '0));

endmodule

// File: rtl/au_dec_cnt.sv
// Loadable, step-programmable down-counter with one-shot, wrap and auto-reload modes.
// Define AU_DEC_CNT_UFL_STICKY_EN to add ufl_clr / ufl_sticky.
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | loaded or stopped; count held, en ignored
// ST_RUN  | counting; en with nonzero step decrements
// ST_DONE | one-shot expired; count held at 0
import au_dec_cnt_pkg::*;

module au_dec_cnt #(
  parameter int WIDTH = 8,
  parameter int SW    = 4,
  parameter int ARCH  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [SW-1:0]    step,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] cnt,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             ufl
`ifdef AU_DEC_CNT_UFL_STICKY_EN
  ,
  input  logic             ufl_clr,
  output logic             ufl_sticky
`endif
);

  if (WIDTH < 1 || SW < 1 || SW > WIDTH || ARCH < ARCH_MIN || ARCH > ARCH_MAX) begin : g_bad_param
    $fatal(1, "au_dec_cnt: illegal parameters WIDTH=%0d SW=%0d ARCH=%0d", WIDTH, SW, ARCH);
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             ufl_q, ufl_d;

  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;
  logic             sub_hit;

  au_dec_step #(
    .WIDTH (WIDTH),
    .SW    (SW),
    .ARCH  (ARCH)
  ) u_step (
    .a      (cnt_q),
    .b      (step),
    .diff   (sub_diff),
    .borrow (sub_borrow),
    .hit    (sub_hit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    ufl_d    = 1'b0;
    if (ld) begin
      cnt_d    = ld_val;
      reload_d = ld_val;
      state_d  = ST_IDLE;
    end else if (state_q == ST_RUN) begin
      if (stop) begin
        state_d = ST_IDLE;
      end else if (en && (step != '0)) begin
        tc_d  = sub_hit;
        ufl_d = sub_borrow;
        case (mode)
          MODE_ONESHOT: begin
            if (sub_hit) begin
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              cnt_d = sub_diff;
            end
          end
          MODE_RELOAD: cnt_d = sub_hit ? reload_q : sub_diff;
          default:     cnt_d = sub_diff;
        endcase
      end
    end else if (start && !stop) begin
      // A one-shot with nothing left to count expires immediately.
      state_d = ((cnt_q == '0) && (mode == MODE_ONESHOT)) ? ST_DONE : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      ufl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      ufl_q    <= ufl_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign tc   = tc_q;
  assign ufl  = ufl_q;

`ifdef AU_DEC_CNT_UFL_STICKY_EN
  logic ufl_sticky_q, ufl_sticky_d;

  // A new underflow takes precedence over a clear in the same cycle.
  always_comb begin
    ufl_sticky_d = ufl_sticky_q;
    if (ufl_d) begin
      ufl_sticky_d = 1'b1;
    end else if (ufl_clr) begin
      ufl_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ufl_sticky_q <= 1'b0;
    end else begin
      ufl_sticky_q <= ufl_sticky_d;
    end
  end

  assign ufl_sticky = ufl_sticky_q;
`endif

endmodule

// File: tb/tb_au_dec_cnt.sv
// Bench for au_dec_cnt: directed scenarios then random traffic, checked against an integer model.
// Exercises ufl_sticky when built with AU_DEC_CNT_UFL_STICKY_EN.
module tb_au_dec_cnt;

  localparam int WIDTH = 8;
  localparam int SW    = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst, ld, start, stop, en;
  logic [WIDTH-1:0] ld_val;
  logic [SW-1:0]    step;
  logic [1:0]       mode;
  logic [WIDTH-1:0] cnt;
  logic             zero, busy, done, tc, ufl;
`ifdef AU_DEC_CNT_UFL_STICKY_EN
  logic             ufl_clr, ufl_sticky;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers, activity as idle/running/finished.
  int m_cnt, m_rel;
  bit m_running, m_finished;
  bit m_tc, m_ufl, m_sticky;

  always #5 clk = ~clk;

  au_dec_cnt #(.WIDTH(WIDTH), .SW(SW), .ARCH(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
    .ld_val (ld_val),
    .start  (start),
    .stop   (stop),
    .en     (en),
    .step   (step),
    .mode   (mode),
    .cnt    (cnt),
    .zero   (zero),
    .busy   (busy),
    .done   (done),
    .tc     (tc),
    .ufl    (ufl)
`ifdef AU_DEC_CNT_UFL_STICKY_EN
    ,
    .ufl_clr    (ufl_clr),
    .ufl_sticky (ufl_sticky)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int  s, md, rem;
    bit  clr;
    s   = int'(step);
    md  = int'(mode);
    clr = 1'b0;
`ifdef AU_DEC_CNT_UFL_STICKY_EN
    clr = ufl_clr;
`endif
    if (rst) begin
      m_cnt = 0; m_rel = 0; m_running = 0; m_finished = 0;
      m_tc = 0; m_ufl = 0; m_sticky = 0;
      return;
    end
    m_tc  = 0;
    m_ufl = 0;
    if (ld) begin
      m_cnt = int'(ld_val); m_rel = int'(ld_val);
      m_running = 0; m_finished = 0;
    end else if (m_running) begin
      if (stop) begin
        m_running = 0;
      end else if (en && s != 0) begin
        m_tc  = (s >= m_cnt);
        m_ufl = (s > m_cnt);
        rem   = m_cnt - s;
        if (md == 0) begin
          if (m_tc) begin m_cnt = 0; m_running = 0; m_finished = 1; end
          else m_cnt = rem;
        end else if (md == 2) begin
          m_cnt = m_tc ? m_rel : rem;
        end else begin
          m_cnt = (rem + MOD) % MOD;
        end
      end
    end else if (start && !stop) begin
      if (m_cnt == 0 && md == 0) begin m_finished = 1; end
      else begin m_running = 1; m_finished = 0; end
    end
    if (m_ufl) m_sticky = 1;
    else if (clr) m_sticky = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("cnt",  32'(cnt),  m_cnt);
    check("zero", 32'(zero), 32'(m_cnt == 0));
    check("busy", 32'(busy), 32'(m_running));
    check("done", 32'(done), 32'(m_finished));
    check("tc",   32'(tc),   32'(m_tc));
    check("ufl",  32'(ufl),  32'(m_ufl));
`ifdef AU_DEC_CNT_UFL_STICKY_EN
    check("ufl_sticky", 32'(ufl_sticky), 32'(m_sticky));
`endif
  endtask

  task automatic drv(input bit r, input bit l, input logic [WIDTH-1:0] lv, input bit s,
                     input bit sp, input bit e, input logic [SW-1:0] st, input logic [1:0] m);
    rst = r; ld = l; ld_val = lv; start = s; stop = sp; en = e; step = st; mode = m;
    tick();
  endtask

  initial begin
    bit r, l, s, sp, e;
    logic [WIDTH-1:0] lv;
    logic [1:0] m;
`ifdef AU_DEC_CNT_UFL_STICKY_EN
    ufl_clr = 1'b0;
`endif
    m_cnt = 0; m_rel = 0; m_running = 0; m_finished = 0;
    m_tc = 0; m_ufl = 0; m_sticky = 0;
    #2;
    drv(1, 0, 8'd0, 0, 0, 0, 4'd0, 2'd0);
    check("reset_cnt",  32'(cnt), 0);
    check("reset_zero", 32'(zero), 1);

    // One-shot: 10 -> 7,4,1,0 with tc/ufl on the last update.
    drv(0, 1, 8'd10, 0, 0, 0, 4'd0, 2'd0);
    drv(0, 0, 8'd0, 1, 0, 1, 4'd3, 2'd0);
    check("start_no_dec", 32'(cnt), 10);
    for (int i = 0; i < 4; i++) drv(0, 0, 8'd0, 0, 0, 1, 4'd3, 2'd0);
    check("oneshot_end_cnt", 32'(cnt), 0);
    check("oneshot_done", 32'(done), 1);
    check("oneshot_ufl", 32'(ufl), 1);
    drv(0, 0, 8'd0, 0, 0, 1, 4'd3, 2'd0);

    // Wrap: 2 - 3 -> 255.
    drv(0, 1, 8'd2, 0, 0, 0, 4'd0, 2'd1);
    drv(0, 0, 8'd0, 1, 0, 0, 4'd0, 2'd1);
    drv(0, 0, 8'd0, 0, 0, 1, 4'd3, 2'd1);
    check("wrap_cnt", 32'(cnt), 255);
    check("wrap_busy", 32'(busy), 1);

    // Auto-reload: exact hit reloads every cycle.
    drv(0, 1, 8'd5, 0, 0, 0, 4'd0, 2'd2);
    drv(0, 0, 8'd0, 1, 0, 0, 4'd0, 2'd2);
    for (int i = 0; i < 3; i++) drv(0, 0, 8'd0, 0, 0, 1, 4'd5, 2'd2);
    check("reload_cnt", 32'(cnt), 5);
    check("reload_tc", 32'(tc), 1);

    // Stop and start together at 6, ignored en, restart.
    drv(0, 1, 8'd8, 0, 0, 0, 4'd0, 2'd0);
    drv(0, 0, 8'd0, 1, 0, 0, 4'd0, 2'd0);
    drv(0, 0, 8'd0, 0, 0, 1, 4'd2, 2'd0);
    drv(0, 0, 8'd0, 1, 1, 1, 4'd2, 2'd0);
    check("stop_hold", 32'(cnt), 6);
    drv(0, 0, 8'd0, 0, 0, 1, 4'd1, 2'd0);
    drv(0, 0, 8'd0, 1, 0, 0, 4'd0, 2'd0);
    drv(0, 0, 8'd0, 0, 0, 1, 4'd1, 2'd0);
    check("restart_dec", 32'(cnt), 5);

    // Load over en, then reset mid-run.
    drv(0, 1, 8'd9, 0, 0, 1, 4'd1, 2'd0);
    check("ld_over_en", 32'(cnt), 9);
    drv(0, 0, 8'd0, 1, 0, 0, 4'd0, 2'd1);
    drv(0, 0, 8'd0, 0, 0, 1, 4'd9, 2'd1);
    drv(1, 0, 8'd0, 0, 0, 1, 4'd1, 2'd1);
    check("rst_mid_zero", 32'(zero), 1);

`ifdef AU_DEC_CNT_UFL_STICKY_EN
    drv(0, 1, 8'd1, 0, 0, 0, 4'd0, 2'd1);
    drv(0, 0, 8'd0, 1, 0, 0, 4'd0, 2'd1);
    ufl_clr = 1'b1;
    drv(0, 0, 8'd0, 0, 0, 1, 4'd2, 2'd1);
    check("sticky_set_wins", 32'(ufl_sticky), 1);
    drv(0, 0, 8'd0, 0, 0, 0, 4'd0, 2'd1);
    check("sticky_cleared", 32'(ufl_sticky), 0);
    ufl_clr = 1'b0;
`endif

    m = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      l  = ($urandom_range(0, 24) == 0);
      lv = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom);
      s  = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) m = 2'($urandom);
`ifdef AU_DEC_CNT_UFL_STICKY_EN
      ufl_clr = ($urandom_range(0, 7) == 0);
`endif
      drv(r, l, lv, s, sp, e, SW'($urandom), m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
